icache: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the

---
 rtl/icache_if.sv | 24 ++
 rtl/icache.sv | 114 +++++++++++
 tb/tb_icache.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetcher and instruction-port signals of the icache in one bundle.
// slave = cache side, master = fetcher plus memory controller side.
interface icache_if;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_clear;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic        flush;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    modport slave (
        input  fetch_valid, fetch_addr, fetch_clear, flush, mem_ready, mem_data,
        output fetch_ready, fetch_inst, mem_valid, mem_addr
    );

    modport master (
        output fetch_valid, fetch_addr, fetch_clear, flush, mem_ready, mem_data,
        input  fetch_ready, fetch_inst, mem_valid, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line read-only instruction cache.
// Latency: hit 1 cycle, miss 2 cycles plus controller time; rdy_in low freezes every register.
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    icache_if.slave  bus
);
    localparam int LINES    = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid_q;
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [31:0]             data_q [LINES];
    logic [31:2]             req_addr;
    logic                    seen_low;
    logic                    cancel;
    logic                    fetch_ready_q;
    logic [31:0]             fetch_inst_q;

    logic [INDEX_BITS-1:0]   fetch_idx;
    logic [TAG_BITS-1:0]     fetch_tag;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_BITS-1:0]     req_tag;
    logic                    accept;
    logic                    hit;
    logic                    fill_done;
    logic                    unused_addr_lsb;

    assign fetch_idx = bus.fetch_addr[INDEX_BITS+1:2];
    assign fetch_tag = bus.fetch_addr[31:INDEX_BITS+2];
    assign req_idx   = req_addr[INDEX_BITS+1:2];
    assign req_tag   = req_addr[31:INDEX_BITS+2];
    assign unused_addr_lsb = ^bus.fetch_addr[1:0];

    assign accept = (state == IDLE) && bus.fetch_valid && !bus.fetch_clear;
    assign hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    // A high ready only counts once it has been seen low during this fill;
    // anything else is left over from the controller's previous job.
    assign fill_done = (state == FILL) && bus.mem_ready && seen_low;

    // Drops in the completion cycle so the controller does not relaunch the fetch.
    assign bus.mem_valid   = (state == FILL) && !(bus.mem_ready && seen_low);
    assign bus.mem_addr    = {req_addr, 2'b00};
    assign bus.fetch_ready = fetch_ready_q;
    assign bus.fetch_inst  = fetch_inst_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            valid_q       <= '0;
            req_addr      <= '0;
            seen_low      <= 1'b0;
            cancel        <= 1'b0;
            fetch_ready_q <= 1'b0;
            fetch_inst_q  <= '0;
        end else if (rdy_in) begin
            if (bus.flush) begin
                valid_q <= '0;
            end
            case (state)
                IDLE: begin
                    fetch_ready_q <= 1'b0;
                    if (accept) begin
                        req_addr <= bus.fetch_addr[31:2];
                        if (hit) begin
                            fetch_ready_q <= 1'b1;
                            fetch_inst_q  <= data_q[fetch_idx];
                        end else begin
                            state    <= FILL;
                            seen_low <= 1'b0;
                            cancel   <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (!bus.mem_ready) begin
                        seen_low <= 1'b1;
                    end
                    if (bus.fetch_clear) begin
                        cancel <= 1'b1;
                    end
                    // The fill always lands, even when cancelled, and wins over a same-cycle flush.
                    if (fill_done) begin
                        valid_q[req_idx] <= 1'b1;
                        fetch_inst_q     <= bus.mem_data;
                        fetch_ready_q    <= !(cancel || bus.fetch_clear);
                        state            <= RESP;
                    end
                end
                RESP: begin
                    fetch_ready_q <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill_done) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= bus.mem_data;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed plus random fetches against a line-map model of the cache and a
// behavioural instruction-port controller whose memory word is address + 3.
module tb_icache;
    localparam int INDEX_BITS = 6;
    localparam int LINES      = 2 ** INDEX_BITS;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    icache_if bus ();

    icache #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: which word address each line currently holds.
    bit          line_valid [LINES];
    logic [31:0] line_addr  [LINES];

    // Controller model: one job per sampled mem_valid while idle, ready low for
    // ctl_lat cycles, then ready high with the word; data is junk afterwards.
    int          ctl_lat  = 5;
    int          jobs     = 0;
    bit          ctl_busy = 1'b0;
    int          ctl_left = 0;
    logic [31:0] ctl_addr = '0;

    always @(posedge clk) begin
        if (rst) begin
            ctl_busy = 1'b0;
        end else if (rdy) begin
            if (ctl_busy) begin
                ctl_left--;
                if (ctl_left == 0) begin
                    ctl_busy = 1'b0;
                    #1;
                    bus.mem_ready = 1'b1;
                    bus.mem_data  = ctl_addr + 32'd3;
                end
            end else if (bus.mem_valid) begin
                ctl_busy = 1'b1;
                ctl_left = ctl_lat;
                ctl_addr = bus.mem_addr;
                jobs++;
                #1;
                bus.mem_ready = 1'b0;
                bus.mem_data  = 32'hBAD0_0000;
            end else if (bus.mem_ready) begin
                #1;
                bus.mem_data = ~(ctl_addr + 32'd3);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) line_valid[i] = 1'b0;
    endtask

    task automatic idle_flush();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        model_flush();
    endtask

    // One fetch; clr_at/stall_at are sample indices after acceptance (0 = unused),
    // flush_done raises flush in the cycle the fill completes.
    task automatic fetch(input logic [31:0] addr, input int clr_at, input int stall_at,
                         input bit flush_done);
        logic [31:0] la, inst, ma;
        int          idx, exp_dly, first, pulses, j0, flush_at;
        bit          hit, cancel, mv_seen, stall;
        la      = {addr[31:2], 2'b00};
        idx     = int'((la >> 2) % LINES);
        hit     = line_valid[idx] && (line_addr[idx] == la);
        cancel  = !hit && (clr_at > 0);
        stall   = !hit && (stall_at > 0);
        exp_dly = hit ? 1 : 3 + ctl_lat + (stall ? 3 : 0);
        flush_at = (!hit && flush_done) ? exp_dly - 1 : 0;
        j0 = jobs; first = 0; pulses = 0; inst = '0; mv_seen = 1'b0; ma = '0;

        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = addr;
        @(posedge clk); #1;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = $urandom;
        for (int n = 1; n <= exp_dly + 2; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            if (bus.fetch_ready) begin
                pulses++;
                if (first == 0) begin
                    first = n;
                    inst  = bus.fetch_inst;
                end
            end
            if (bus.mem_valid && !mv_seen) begin
                mv_seen = 1'b1;
                ma      = bus.mem_addr;
            end
            bus.fetch_clear = (n == clr_at);
            rdy             = !(stall && n >= stall_at && n < stall_at + 3);
            bus.flush       = (n == flush_at);
        end
        rdy             = 1'b1;
        bus.fetch_clear = 1'b0;
        bus.flush       = 1'b0;

        check("pulse_count", 32'(pulses), cancel ? 32'd0 : 32'd1);
        if (!cancel) begin
            check("latency", 32'(first), 32'(exp_dly));
            check("fetch_inst", inst, la + 32'd3);
        end
        check("jobs", 32'(jobs - j0), hit ? 32'd0 : 32'd1);
        check("mem_valid_seen", 32'(mv_seen), hit ? 32'd0 : 32'd1);
        if (!hit) check("mem_addr", ma, la);

        if (flush_at > 0) model_flush();
        if (!hit) begin
            line_valid[idx] = 1'b1;
            line_addr[idx]  = la;
        end
    endtask

    logic [31:0] bb [4];
    int          j0;
    int          pulses;

    initial begin
        rst             = 1'b1;
        rdy             = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = '0;
        bus.fetch_clear = 1'b0;
        bus.flush       = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.mem_data    = '0;
        model_flush();
        repeat (3) @(posedge clk);
        #1;
        check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        check("rst_fetch_inst", bus.fetch_inst, 32'd0);
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss, repeat hit, then conflicts on the same index.
        fetch(32'h0000_0010, 0, 0, 1'b0);
        fetch(32'h0000_0010, 0, 0, 1'b0);
        fetch(32'h0000_0110, 0, 0, 1'b0);
        fetch(32'h0000_0012, 0, 0, 1'b0);

        // Stale ready from the previous job at issue, longer controller time.
        ctl_lat = 7;
        fetch(32'h0000_0200, 0, 0, 1'b0);
        ctl_lat = 5;

        // Cancel during fill: line still written, so the refetch hits.
        fetch(32'h0000_0040, 2, 0, 1'b0);
        fetch(32'h0000_0040, 0, 0, 1'b0);

        // Clear together with valid: request dropped entirely.
        j0 = jobs;
        pulses = 0;
        bus.fetch_valid = 1'b1;
        bus.fetch_clear = 1'b1;
        bus.fetch_addr  = 32'h0000_0400;
        @(posedge clk); #1;
        bus.fetch_valid = 1'b0;
        bus.fetch_clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.fetch_ready || bus.mem_valid) pulses++;
            @(posedge clk); #1;
        end
        check("clr_valid_activity", 32'(pulses), 32'd0);
        check("clr_valid_jobs", 32'(jobs - j0), 32'd0);

        // Back-to-back hits, one response per cycle.
        bb[0] = 32'h20; bb[1] = 32'h24; bb[2] = 32'h28; bb[3] = 32'h20;
        for (int k = 0; k < 3; k++) fetch(bb[k], 0, 0, 1'b0);
        bus.fetch_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.fetch_addr = bb[k];
            @(posedge clk); #1;
            check("b2b_ready", 32'(bus.fetch_ready), 32'd1);
            check("b2b_inst", bus.fetch_inst, bb[k] + 32'd3);
        end
        bus.fetch_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_ready_drop", 32'(bus.fetch_ready), 32'd0);

        // Flush, then a miss with a 3-cycle global stall in the middle of the fill.
        idle_flush();
        fetch(32'h0000_0010, 0, 3, 1'b0);
        fetch(32'h0000_0010, 0, 0, 1'b0);

        // Flush coinciding with fill completion keeps only the new line.
        fetch(32'h0000_0024, 0, 0, 1'b0);
        fetch(32'h0000_0030, 0, 0, 1'b1);
        fetch(32'h0000_0030, 0, 0, 1'b0);
        fetch(32'h0000_0024, 0, 0, 1'b0);

        // Random mix over a small footprint so hits and conflicts both occur.
        for (int r = 0; r < 40; r++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) |
                32'($urandom_range(0, 3));
            ctl_lat = $urandom_range(5, 8);
            if ($urandom_range(0, 9) == 0) idle_flush();
            fetch(a, ($urandom_range(0, 7) == 0) ? 2 : 0,
                  ($urandom_range(0, 5) == 0) ? 3 : 0,
                  $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
